// File: rtl/fifo_8_reader_pkg.sv
// fifo_8_reader_pkg
// Shared sizing for the FIFO_8 read-side controller.
//   DEFAULT_DEPTH / DEFAULT_WIDTH : default FIFO geometry
//   CNT_W                         : occupancy counter width for the default depth
//   BUF_DEPTH / BUF_CNT_W         : output buffer size and its counter width
package fifo_8_reader_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 8;

  // Occupancy must represent 0..depth inclusive, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W     = cnt_width(DEFAULT_DEPTH);
  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = 2;

endpackage

// File: rtl/fifo_8_reader_skid.sv
// fifo_8_reader_skid
// Two-entry in-order output buffer. Entry 0 is always the head.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push, din : write one word (caller guarantees space)
//   pop       : remove the head word (caller guarantees it exists)
//   head      : current head word (registered)
//   buf_cnt   : number of stored words, 0..2
module fifo_8_reader_skid
  import fifo_8_reader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     din,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head,
  output logic [BUF_CNT_W-1:0] buf_cnt
);

  logic [BUF_DEPTH-1:0][WIDTH-1:0] mem_reg;
  logic [BUF_DEPTH-1:0][WIDTH-1:0] mem_next;
  logic [BUF_CNT_W-1:0]            cnt_reg;
  logic [BUF_CNT_W-1:0]            base;

  // Words that remain after this cycle's pop; a push lands right behind them,
  // which keeps order intact when push and pop coincide.
  assign base = cnt_reg - {{(BUF_CNT_W-1){1'b0}}, pop};

  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      if (gi < BUF_DEPTH - 1) begin : g_mid
        assign mem_next[gi] = (push && base == BUF_CNT_W'(gi)) ? din :
                              (pop ? mem_reg[gi+1] : mem_reg[gi]);
      end else begin : g_last
        // The tail slot is left stale on pop; it is unreachable until rewritten.
        assign mem_next[gi] = (push && base == BUF_CNT_W'(gi)) ? din : mem_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_reg <= '0;
      cnt_reg <= '0;
    end else begin
      mem_reg <= mem_next;
      cnt_reg <= base + {{(BUF_CNT_W-1){1'b0}}, push};
    end
  end

  assign head    = mem_reg[0];
  assign buf_cnt = cnt_reg;

endmodule

// File: rtl/fifo_8_reader.sv
// fifo_8_reader
// Read-side controller for FIFO_8: mirrors FIFO occupancy from the writer's
// wen and its own ren, issues ren only when a word is present and there is
// room downstream, and presents the data as a valid/ready stream.
// Optional macro FIFO_8_READER_ERRCHK_EN: when defined, a word returned with
// fifo_error is dropped and sets the sticky err flag; otherwise fifo_error is
// ignored and err is 0.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   wen_mon     : monitored copy of the writer's wen
//   ren         : read strobe to the FIFO
//   fifo_dout   : FIFO read data, valid the cycle after ren
//   fifo_error  : FIFO error flag, sampled with fifo_dout
//   m_data, m_valid, m_ready : output stream
//   count       : mirrored FIFO occupancy 0..DEPTH
//   err         : sticky read-error flag
module fifo_8_reader
  import fifo_8_reader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wen_mon,
  output logic                        ren,
  input  logic [WIDTH-1:0]            fifo_dout,
  input  logic                        fifo_error,
  output logic [WIDTH-1:0]            m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        err
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0]        cnt_reg;
  logic                 inflight_reg;
  logic [BUF_CNT_W-1:0] buf_cnt;
  logic                 pop;
  logic                 push;
  logic                 inc;
  logic                 ren_int;

  assign pop = m_valid & m_ready;

  // Buffer slots committed = stored + in flight; a pop this cycle frees one.
  // m_ready reaches ren combinationally so full throughput is sustained.
  assign ren_int = (cnt_reg != '0) &&
                   (({1'b0, buf_cnt} + {2'b00, inflight_reg}) <
                    (3'(BUF_DEPTH) + {2'b00, pop}));

  // The FIFO drops a write that collides with a read or arrives when full.
  assign inc = wen_mon & ~ren_int & (cnt_reg < CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      inflight_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_reg + CW'(inc) - CW'(ren_int);
      inflight_reg <= ren_int;
    end
  end

`ifdef FIFO_8_READER_ERRCHK_EN
  logic err_reg;

  assign push = inflight_reg & ~fifo_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (inflight_reg & fifo_error) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  logic unused_fifo_error;

  assign unused_fifo_error = fifo_error;
  assign push              = inflight_reg;
  assign err               = 1'b0;
`endif

  fifo_8_reader_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     (fifo_dout),
    .pop     (pop),
    .head    (m_data),
    .buf_cnt (buf_cnt)
  );

  assign m_valid = (buf_cnt != '0);
  assign ren     = ren_int;
  assign count   = cnt_reg;

endmodule

// File: doc/fifo_8_reader.md
# fifo_8_reader

Read-side controller for the 8-deep, 8-bit `FIFO_8` buffer. It mirrors FIFO occupancy by monitoring the writer's `wen` alongside its own `ren`, and issues `ren` only when a word is present. It turns the FIFO's one-cycle read latency into a registered valid/ready stream for the downstream consumer. It sits between `FIFO_8` (read port) and any stream sink, replacing hand-driven `ren` sequences.

## Interface
Parameters:
- `DEPTH`, 8, FIFO capacity in words; must match the attached FIFO.
- `WIDTH`, 8, data width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wen_mon`  in  1  copy of the writer's `wen` into the FIFO (monitor only).
- `ren`  out  1  read strobe to the FIFO.
- `fifo_dout`  in  WIDTH  FIFO read data; valid the cycle after an accepted `ren`.
- `fifo_error`  in  1  FIFO error flag; sampled with `fifo_dout`.
- `m_data`  out  WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from the sink.
- `count`  out  $clog2(DEPTH)+1  mirrored FIFO occupancy, 0..DEPTH.
- `err`  out  1  sticky read-error flag (see Configuration).

## Operation
- FIFO rules the mirror must track:
  - `ren` has priority over `wen`; a `wen` in the same cycle as `ren` is dropped by the FIFO.
  - `wen` when full is dropped.
- Occupancy update:
  - `cnt_next = cnt + inc - dec`.
  - `inc = wen_mon & ~ren & (cnt < DEPTH)`.
  - `dec = ren`.
  - `count` never exceeds DEPTH and never underflows.
- Read issue: `ren = (cnt != 0) & (2 - buf_cnt - inflight + pop) > 0`.
  - `inflight` is a 1-bit register: `ren` of the previous cycle.
  - `buf_cnt` is 0..2, the occupancy of the output buffer.
  - `pop = m_valid & m_ready`.
  - This is a combinational path from `m_ready` to `ren`; it is permitted.
- Capture: when `inflight == 1`, `fifo_dout` is pushed into the 2-entry output buffer in the same cycle.
  - The buffer can never overflow, by construction of the `ren` rule.
- Stream:
  - `m_valid = (buf_cnt != 0)`; `m_data` is the head entry.
  - `m_data`/`m_valid` are held stable while `m_valid & ~m_ready`.
  - Push and pop in the same cycle are both honoured; order is preserved.
- Empty mirror (`cnt == 0`): `ren` stays 0; the block never deliberately triggers `fifo_error`.

## Timing
- Reset values (async on `rst` high):
  - `cnt = 0`, `inflight = 0`, `buf_cnt = 0`.
  - `m_valid = 0`, `m_data = 0`, `err = 0`.
  - `ren` is 0 while `rst` is high.
- Latency with the sink ready:
  - Write edge N → `ren` high in cycle N+1 → FIFO output edge N+1 → buffer edge N+2.
  - `m_valid` is first high after edge N+2.
- Throughput: one word per cycle sustained while `m_ready` stays high and `cnt > 0`.
- Back-pressure: with `m_ready = 0`, at most 2 words leave the FIFO; `ren` then stays low.
- Reset mid-operation: all buffered and in-flight data is discarded. The FIFO must be reset in the same cycle.

## Configuration
- Macro `FIFO_8_READER_ERRCHK_EN`.
- Defined:
  - `err` is set when `inflight & fifo_error`; that word is not pushed into the buffer.
  - `err` stays set until `rst`.
- Undefined:
  - `fifo_error` is ignored and every in-flight word is pushed.
  - `err` is tied to 0.

## Structure
- Package `fifo_8_reader_pkg` holds:
  - `DEPTH`/`WIDTH` defaults.
  - `CNT_W = $clog2(DEPTH)+1`.
  - `BUF_DEPTH = 2`.
- Sub-module `fifo_8_reader_skid`: the 2-entry output buffer with push/pop, `buf_cnt` and head output.
- Top level contains the occupancy mirror, `inflight`, issue logic and error logic.

## Test plan
- Reset, then `wen_mon` pulses writing 56, 11, 42 with `m_ready = 1` → `m_data` = 56, 11, 42 on consecutive cycles. First `m_valid` appears 2 cycles after the first write edge; `count` returns to 0.
- 8 writes (56, 11, 42, 10, 23, 20, 6, 85) with `m_ready = 0` → `ren` pulses twice, `count` rises to 6 and holds, `m_data = 56` stable. Releasing `m_ready` drains all 8 in order.
- `count = 8` and a further `wen_mon` of 45 with `m_ready = 0` → `count` stays 8, and 45 never appears on `m_data`.
- `wen_mon` asserted during a cycle with `ren = 1` → that write is not counted; later output skips the value.
- With `FIFO_8_READER_ERRCHK_EN` defined, force `fifo_error = 1` on an in-flight cycle → `err = 1` next edge, the word is dropped, and `err` clears only on `rst`.
- Assert `rst` with 2 words buffered → `m_valid`, `count` and `ren` go to 0 immediately (async); after release, new writes stream normally.
